product_accumulator: RTL and testbench

- Downstream consumer of the 8x8 adder-tree multiplier's registered 16-bit product.
- Accumulates a frame of COUNT products into one dot-product result and presents it on a valid/ready output handshake.
- Result is double-buffered, so the next frame accumulates while the previous result waits for the sink.
- Upstream backpressure via in_ready; the multiplier's issue logic gates ena/enb with it.

---
 rtl/product_accumulator.sv | 104 ++++++++++
 tb/tb_product_accumulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Frame accumulator for multiplier products with a double-buffered
// valid/ready result output.
module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int COUNT  = 8,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [ACC_W-1:0]  result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  output logic [7:0]        frame_cnt
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_acc_ovf;
  logic             r_ovf;
  logic             r_out_valid;
  logic [7:0]       r_frame_cnt;

  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_next;
  logic             w_carry;
  logic             w_last;
  logic             w_ready;
  logic             w_take;
  logic             w_pop;

  assign w_last  = (r_cnt == LAST);
  assign w_sum   = {1'b0, r_acc}
                 + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign w_carry = w_sum[ACC_W];

  // Saturation re-clamps on every later carry, so it sticks at all-ones.
  always_comb begin
    w_next = w_sum[ACC_W-1:0];
    if (SAT != 0 && w_carry)
      w_next = '1;
  end

  // Only the final beat of a frame can stall, and only on a full buffer.
  assign w_ready = !clr && !(w_last && r_out_valid && !out_ready);
  assign w_take  = in_valid && w_ready;
  assign w_pop   = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_acc_ovf <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else if (clr) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_acc_ovf <= 1'b0;
    end else if (w_take) begin
      if (w_last) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_acc_ovf <= 1'b0;
        r_result  <= w_next;
        r_ovf     <= r_acc_ovf | w_carry;
      end else begin
        r_acc     <= w_next;
        r_cnt     <= r_cnt + CW'(1);
        r_acc_ovf <= r_acc_ovf | w_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (w_take && w_last)
        r_out_valid <= 1'b1;
      else if (w_pop)
        r_out_valid <= 1'b0;
      if (w_pop)
        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign in_ready  = w_ready;
  assign result    = r_result;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator across several parameter sets
// sharing one input stream.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] prod = '0;
  logic        in_valid = 1'b0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b1;

  logic        ir8, ov8, of8;
  logic [23:0] rs8;
  logic [7:0]  fc8;
  logic        irw, ovw, ofw;
  logic [16:0] rsw;
  logic [7:0]  fcw;
  logic        irs, ovs, ofs;
  logic [16:0] rss;
  logic [7:0]  fcs;
  logic        ir4, ov4, of4;
  logic [23:0] rs4;
  logic [7:0]  fc4;
  logic        ir1, ov1, of1;
  logic [23:0] rs1;
  logic [7:0]  fc1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  product_accumulator u8 (
    .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid),
    .in_ready(ir8), .clr(clr), .result(rs8), .out_valid(ov8),
    .out_ready(out_ready), .ovf(of8), .frame_cnt(fc8));

  product_accumulator #(.ACC_W(17), .COUNT(3), .SAT(0)) uw (
    .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid),
    .in_ready(irw), .clr(clr), .result(rsw), .out_valid(ovw),
    .out_ready(out_ready), .ovf(ofw), .frame_cnt(fcw));

  product_accumulator #(.ACC_W(17), .COUNT(3), .SAT(1)) us (
    .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid),
    .in_ready(irs), .clr(clr), .result(rss), .out_valid(ovs),
    .out_ready(out_ready), .ovf(ofs), .frame_cnt(fcs));

  product_accumulator #(.COUNT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid),
    .in_ready(ir4), .clr(clr), .result(rs4), .out_valid(ov4),
    .out_ready(out_ready), .ovf(of4), .frame_cnt(fc4));

  product_accumulator #(.COUNT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid),
    .in_ready(ir1), .clr(clr), .result(rs1), .out_valid(ov1),
    .out_ready(out_ready), .ovf(of1), .frame_cnt(fc1));

  typedef struct {
    logic [15:0] prod;
    logic        v;
    logic        c;
    logic        ordy;
    logic        irdy;
    logic        ov;
    logic [23:0] res;
    logic        ovf;
    logic [7:0]  fc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [15:0] p, input logic v,
                      input logic ordy, input logic irdy,
                      input logic ov, input logic [23:0] res,
                      input logic [7:0] fc);
    vec_t e;
    e.prod = p; e.v = v; e.c = 1'b0; e.ordy = ordy;
    e.irdy = irdy; e.ov = ov; e.res = res; e.ovf = 1'b0; e.fc = fc;
    tbl.push_back(e);
  endtask

  task automatic drive(input logic [15:0] p, input logic v,
                       input logic c, input logic ordy);
    prod = p; in_valid = v; clr = c; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // basic frame, out_ready high
    for (int i = 0; i < 8; i++)
      addv(16'd65025, 1, 1, 1, i == 7, (i == 7) ? 24'd520200 : 24'd0, 0);
    addv(16'd0, 0, 1, 1, 0, 24'd520200, 1);
    // second frame left pending
    for (int i = 0; i < 8; i++)
      addv(16'd65025, 1, 0, 1, i == 7, 24'd520200, 1);
    // third frame streams behind the pending result
    for (int i = 0; i < 7; i++)
      addv(16'd1, 1, 0, 1, 1, 24'd520200, 1);
    addv(16'd1, 1, 0, 0, 1, 24'd520200, 1);
    addv(16'd1, 1, 0, 0, 1, 24'd520200, 1);
    addv(16'd1, 1, 1, 1, 1, 24'd8, 2);
    addv(16'd0, 0, 1, 1, 0, 24'd8, 3);

    do_reset();
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_result", rs8, 0);
    chk("rst_ovf", of8, 0);
    chk("rst_frame_cnt", fc8, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].prod, tbl[i].v, tbl[i].c, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), ir8, tbl[i].irdy);
      step();
      chk($sformatf("v%0d_out_valid", i), ov8, tbl[i].ov);
      chk($sformatf("v%0d_result", i), rs8, tbl[i].res);
      chk($sformatf("v%0d_ovf", i), of8, tbl[i].ovf);
      chk($sformatf("v%0d_frame_cnt", i), fc8, tbl[i].fc);
    end

    // overflow wrap and saturate on ACC_W=17, COUNT=3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(16'd65025, 1, 0, 1);
      step();
    end
    chk("wrap_valid", ovw, 1);
    chk("wrap_result", rsw, 64003);
    chk("wrap_ovf", ofw, 1);
    chk("sat_result", rss, 131071);
    chk("sat_ovf", ofs, 1);
    for (int i = 1; i <= 3; i++) begin
      drive(16'(i), 1, 0, 1);
      step();
    end
    chk("wrap2_result", rsw, 6);
    chk("wrap2_ovf", ofw, 0);
    chk("wrap2_frame_cnt", fcw, 1);
    chk("sat2_result", rss, 6);
    chk("sat2_ovf", ofs, 0);

    // clr mid-frame on COUNT=4, COUNT=1 rides along
    do_reset();
    drive(16'd10, 1, 0, 1);
    step();
    chk("c1_result", rs1, 10);
    chk("c1_valid", ov1, 1);
    drive(16'd20, 1, 0, 1);
    step();
    chk("c1_result2", rs1, 20);
    chk("c1_frame_cnt", fc1, 1);
    drive(16'd99, 1, 1, 1);
    #1;
    chk("clr_in_ready", ir4, 0);
    chk("clr_c1_in_ready", ir1, 0);
    step();
    chk("clr_c1_result", rs1, 20);
    for (int i = 1; i <= 4; i++) begin
      drive(16'(i), 1, 0, 0);
      step();
    end
    chk("clr_result", rs4, 10);
    chk("clr_valid", ov4, 1);
    chk("clr_ovf", of4, 0);
    drive(16'd99, 1, 1, 0);
    step();
    chk("clr_hold_result", rs4, 10);
    chk("clr_hold_valid", ov4, 1);
    drive(16'd0, 0, 0, 1);
    step();
    chk("clr_pop_valid", ov4, 0);
    chk("clr_pop_frame_cnt", fc4, 1);

    // async reset mid-frame with a pending result
    for (int i = 0; i < 10; i++) begin
      drive(16'd1, 1, 0, 0);
      step();
    end
    chk("ar_pre_valid", ov8, 1);
    chk("ar_pre_result", rs8, 8);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", ov8, 0);
    chk("ar_result", rs8, 0);
    chk("ar_frame_cnt", fc8, 0);
    drive(16'd0, 0, 0, 1);
    #3;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      drive(16'd2, 1, 0, 1);
      step();
    end
    chk("ar_new_result", rs8, 16);
    chk("ar_new_valid", ov8, 1);
    drive(16'd0, 0, 0, 1);
    step();
    chk("ar_new_frame_cnt", fc8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
